// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - byte-stream loader that fills instruction memory and gates core reset
module instr_mem_loader #(
  parameter int ADDR_W  = 5,
  parameter int N_WORDS = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // word_idx carries one bit more than the address field so that it can
  // reach N_WORDS itself when N_WORDS fills the whole address space.
  localparam int IDX_W = ADDR_W - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [IDX_W-1:0] word_idx;
  logic [IDX_W-1:0] word_cnt;
  logic [IDX_W-1:0] idx_inc;
  logic [1:0]       byte_cnt;
  logic [23:0]      shift;
  logic             loaded;
  logic             take;
  logic             hdr_ok;
  logic [31:0]      hdr_val;

  assign take      = byte_valid & byte_ready;
  assign hdr_val   = {24'd0, byte_in};
  assign hdr_ok    = (hdr_val >= 32'd1) && (hdr_val <= 32'(N_WORDS));
  assign idx_inc   = word_idx + 1'b1;
  // The core runs only once a full program has landed in memory.
  assign cpu_reset = ~loaded;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and per-state control outputs.
  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = S_HDR;
        end
      end
      S_HDR: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          state_next = hdr_ok ? S_COLLECT : S_IDLE;
        end
      end
      S_COLLECT: begin
        byte_ready = 1'b1;
        if (byte_valid && (byte_cnt == 2'd3)) begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_we     = 1'b1;
        state_next = (idx_inc == word_cnt) ? S_DONE : S_COLLECT;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  // Session bookkeeping, byte assembly and the registered write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_idx  <= '0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      shift     <= '0;
      loaded    <= 1'b0;
      error     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            loaded   <= 1'b0;
            error    <= 1'b0;
            word_idx <= '0;
            byte_cnt <= '0;
            shift    <= '0;
          end
        end
        S_HDR: begin
          if (take) begin
            if (hdr_ok) begin
              word_cnt <= hdr_val[IDX_W-1:0];
            end else begin
              error <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (take) begin
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= {shift[15:0], byte_in};
            // Latch address and word here so they are stable during the strobe.
            if (byte_cnt == 2'd3) begin
              mem_addr  <= {word_idx[ADDR_W-3:0], 2'b00};
              mem_wdata <= {shift, byte_in};
            end
          end
        end
        S_WRITE: begin
          word_idx <= idx_inc;
        end
        S_DONE: begin
          loaded <= 1'b1;
        end
        default: begin
          loaded <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - randomized self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

  localparam int ADDR_W  = 5;
  localparam int N_WORDS = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        byte_in = 8'd0;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;

  instr_mem_loader #(.ADDR_W(ADDR_W), .N_WORDS(N_WORDS)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  int         n_cmp = 0;
  int         n_mis = 0;
  int         cyc = 0;
  wr_t        exp_q[$];
  int         we_cyc_q[$];
  int         done_cyc_q[$];
  logic [7:0] stream_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Cycle counter used to time strobes and done pulses.
  always @(posedge clock) cyc <= cyc + 1;

  // Write and done monitor, sampled on the falling edge.
  always @(negedge clock) begin
    wr_t w;
    if (!reset) begin
      if (mem_we) begin
        we_cyc_q.push_back(cyc);
        check("ready_low_in_write", byte_ready, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", mem_we, 0);
        end else begin
          w = exp_q.pop_front();
          check("write_addr", mem_addr, w.addr);
          check("write_data", mem_wdata, w.data);
        end
      end
      if (done) begin
        done_cyc_q.push_back(cyc);
        check("cpu_reset_during_done", cpu_reset, 1);
      end
    end
  end

  task automatic build_stream(input int hdr, input int nwords);
    stream_q.delete();
    stream_q.push_back(8'(hdr));
    for (int i = 0; i < 4 * nwords; i++) stream_q.push_back(8'($urandom));
  endtask

  task automatic run_session(input bit gaps, input int start_at, input int reset_at);
    int cnt, total, idx, budget, we_base, done_base;
    bit ok, acc;
    cnt   = stream_q[0];
    ok    = (cnt >= 1) && (cnt <= N_WORDS);
    total = ok ? 1 + 4 * cnt : 1;
    exp_q.delete();
    if (ok) begin
      for (int i = 0; i < cnt; i++) begin
        wr_t w;
        w.addr = ADDR_W'(4 * i);
        w.data = {stream_q[1 + 4 * i], stream_q[2 + 4 * i], stream_q[3 + 4 * i], stream_q[4 + 4 * i]};
        exp_q.push_back(w);
      end
    end
    we_base   = we_cyc_q.size();
    done_base = done_cyc_q.size();

    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("ready_in_hdr", byte_ready, 1);
    check("cpu_reset_loading", cpu_reset, 1);
    check("error_cleared_on_start", error, 0);

    idx    = 0;
    budget = 800;
    while (idx < total && budget > 0) begin
      byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_in    = byte_valid ? stream_q[idx] : 8'($urandom);
      start      = (idx == start_at);
      acc        = byte_valid && byte_ready;
      @(posedge clock);
      if (acc) idx++;
      @(negedge clock);
      budget--;
      if (reset_at >= 0 && idx == reset_at) begin
        byte_valid = 1'b0;
        start      = 1'b0;
        reset      = 1'b1;
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_ready", byte_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        reset = 1'b0;
        exp_q.delete();
        return;
      end
    end
    check("stream_consumed", idx, total);
    byte_valid = 1'b0;
    start      = 1'b0;

    budget = 20;
    while (busy && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    check("idle_reached", busy, 0);
    check("writes_left", exp_q.size(), 0);
    check("write_count", we_cyc_q.size() - we_base, ok ? cnt : 0);
    check("done_count", done_cyc_q.size() - done_base, ok ? 1 : 0);
    check("error_flag", error, !ok);
    check("cpu_reset_after", cpu_reset, !ok);
    check("ready_idle", byte_ready, 0);
    if (ok && !gaps && we_cyc_q.size() - we_base == cnt && done_cyc_q.size() > done_base) begin
      for (int i = we_base + 1; i < we_cyc_q.size(); i++)
        check("we_spacing", we_cyc_q[i] - we_cyc_q[i - 1], 5);
      check("done_after_last_write", done_cyc_q[done_base] - we_cyc_q[we_cyc_q.size() - 1], 1);
    end
  endtask

  // Overall run bound.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Directed scenarios followed by randomized sessions.
  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_busy", busy, 0);
    check("reset_ready", byte_ready, 0);
    check("reset_we", mem_we, 0);
    check("reset_addr", mem_addr, 0);
    check("reset_wdata", mem_wdata, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    check("reset_cpu_reset", cpu_reset, 1);
    reset = 1'b0;
    @(negedge clock);
    check("idle_cpu_reset_unloaded", cpu_reset, 1);

    stream_q = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    run_session(1'b0, -1, -1);
    run_session(1'b1, -1, -1);

    stream_q = '{8'h00};
    run_session(1'b0, -1, -1);
    stream_q = '{8'h09};
    run_session(1'b0, -1, -1);

    build_stream(8, 8);
    run_session(1'b0, -1, -1);

    build_stream(3, 3);
    run_session(1'b1, 3, -1);

    build_stream(3, 3);
    run_session(1'b0, -1, 7);
    build_stream(2, 2);
    run_session(1'b0, -1, -1);

    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 6) == 0) begin
        n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(N_WORDS + 1, 255);
        build_stream(n, 0);
      end else begin
        n = $urandom_range(1, N_WORDS);
        build_stream(n, n);
      end
      run_session(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
